dbf_channel_dynfocus: RTL and testbench
=======================================

# dbf_channel_dynfocus

Parametrised receive-beamformer channel with dynamic focusing. Per accepted ADC sample it applies a zone-indexed coarse delay (circular sample buffer), a linear-interpolation fine delay, apodisation weighting, and rounding/saturation. It feeds the DBF channel summer and replaces the fixed per-channel coarse-only blocks.

## Interface
- INPUT_WD, 14, signed ADC sample width
- APO_WD, 16, signed apodisation weight width
- ADDR_WD, 10, delay-LUT address width (2^ADDR_WD focal zones)
- CD_WD, 8, coarse-delay width; sample buffer depth 2^CD_WD
- FRAC_WD, 4, fine-delay fraction width
- ZONE_LEN, 64, accepted samples per focal zone
- SHIFT, 0, LSBs dropped (with rounding) from the apodised product
- OUT_WD, 32, signed output width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  receive window active
- tx_en  in  1  transmit in progress; blocks sample acceptance
- ch_in  in  INPUT_WD  signed input sample
- apo_din  in  APO_WD  signed apodisation weight, sampled with ch_in
- lut_we  in  1  delay-LUT write strobe
- lut_addr  in  ADDR_WD  delay-LUT write address
- lut_wdata  in  CD_WD+FRAC_WD  delay word {coarse c, fraction f}
- dout  out  OUT_WD  apodised, delayed sample
- dout_valid  out  1  dout qualifier
- cd_dout  out  INPUT_WD  coarse-delayed sample (debug tap)
- cd_dout_valid  out  1  cd_dout qualifier

## Operation
- Accept: acc = start & ~tx_en. Each accepted cycle writes ch_in to buf[wp], wp = wp+1 mod 2^CD_WD, and fill count n increments, saturating at 2^CD_WD.
- LUT: single write port. A write lands only when lut_we=1 and start=0. lut_we while start=1 is ignored.
- Zones: zaddr starts at 0. On each accept, zcnt increments. When zcnt=ZONE_LEN-1 it wraps to 0 and zaddr increments, saturating at 2^ADDR_WD-1. A sample uses LUT[zaddr] as it stands at that sample's acceptance.
- Coarse: c is clamped to 2^CD_WD-2. The current sample has index k=n-1.
  - x0 = sample k-c; x0 = 0 if n ≤ c.
  - x1 = sample k-c-1; x1 = 0 if n ≤ c+1.
- Fine: y = x0 + (((x1-x0)*f + 2^(FRAC_WD-1)) >>> FRAC_WD).
  - Difference is computed at INPUT_WD+1 bits, and the arithmetic shift is a floor.
  - y always lies between x0 and x1, so it fits INPUT_WD signed.
- Apodise: p = y * apo, at INPUT_WD+APO_WD bits signed. apo is registered alongside the sample.
- Output: r = (p + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT.
  - If r fits OUT_WD it is sign-extended.
  - Otherwise it saturates to +2^(OUT_WD-1)-1 or -2^(OUT_WD-1).
- States:
  - IDLE (start=0): pointers, n, zcnt and zaddr held at 0; outputs 0.
  - ACQ (start=1, tx_en=0): samples accepted.
  - HOLD (start=1, tx_en=1): no accept; all counters hold; in-flight samples drain.
  - Transitions follow start/tx_en every cycle.
- start falling: wp, n, zcnt and zaddr clear next cycle. All pipeline valids clear, so in-flight samples are dropped. Buffer contents are left stale but masked by n.

## Timing
- Reset: dout=0, dout_valid=0, cd_dout=0, cd_dout_valid=0. Pointers, counters, zaddr and pipeline registers clear. LUT and buffer contents are undefined.
- Pipeline: all stages advance every cycle; a valid bit travels with each sample.
  - S1: accept, buffer write, LUT read.
  - S2: buffer reads of x0/x1.
  - S3: interpolation; cd_dout=x0 and cd_dout_valid registered here.
  - S4: multiply.
  - S5: round/saturate into dout.
- Latency: a sample accepted in cycle t gives cd_dout_valid at t+3 and dout_valid at t+5.
- Valid shape: dout_valid is high for exactly one cycle per accepted sample, in order. Invalid cycles drive dout=0 and cd_dout=0.
- Read-during-write: with c=0, x0 is the sample being written in the same cycle (write-first).

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs 0 immediately; after release, first accept yields dout_valid 5 cycles later.
- Pass-through: LUT[0]={0,0}, apo=1, ramp 1,2,3,… → dout 1,2,3,… at latency 5; cd_dout identical at latency 3.
- Coarse and warm-up: LUT[0]={3,0}, ramp from 1 → dout 0,0,0,1,2,…; tx_en high for 2 cycles mid-ramp → 2-cycle gap in dout_valid, sequence continues unbroken.
- Fine: c=0, f=8, apo=1.
  - Inputs 0,100 → second output 50.
  - Inputs 1,2 → 2.
  - Inputs -1,-2 → -1 (half rounds up).
- Zones: ZONE_LEN=4, LUT[0]={0,0}, LUT[1]={2,0}, ramp from 1 → outputs 1,2,3,4 then 3,4,5,…; lut_we during start leaves outputs unchanged.
- Apodisation and saturation: OUT_WD=16, SHIFT=0, input 8191, apo=32767 → dout=32767; input -8192, apo=32767 → -32768; apo=-2, input 100 → -200.

Source files
------------

// File: rtl/dbf_channel_dynfocus_if.sv
// Sample/apodisation stream, delay-LUT write port and output taps of one
// dynamic-focus beamformer channel.
interface dbf_channel_dynfocus_if #(
  parameter int INPUT_WD = 14,
  parameter int APO_WD   = 16,
  parameter int ADDR_WD  = 10,
  parameter int CD_WD    = 8,
  parameter int FRAC_WD  = 4,
  parameter int OUT_WD   = 32
);
  logic                             start;
  logic                             tx_en;
  logic signed [INPUT_WD-1:0]       ch_in;
  logic signed [APO_WD-1:0]         apo_din;
  logic                             lut_we;
  logic [ADDR_WD-1:0]               lut_addr;
  logic [CD_WD+FRAC_WD-1:0]         lut_wdata;
  logic signed [OUT_WD-1:0]         dout;
  logic                             dout_valid;
  logic signed [INPUT_WD-1:0]       cd_dout;
  logic                             cd_dout_valid;

  modport master (
    output start, tx_en, ch_in, apo_din, lut_we, lut_addr, lut_wdata,
    input  dout, dout_valid, cd_dout, cd_dout_valid
  );

  modport slave (
    input  start, tx_en, ch_in, apo_din, lut_we, lut_addr, lut_wdata,
    output dout, dout_valid, cd_dout, cd_dout_valid
  );
endinterface

// File: rtl/dbf_channel_dynfocus.sv
// Receive-beamformer channel: zone-indexed coarse delay from a circular sample
// buffer, linear-interpolation fine delay, apodisation and round/saturate.
module dbf_channel_dynfocus #(
  parameter int INPUT_WD = 14,
  parameter int APO_WD   = 16,
  parameter int ADDR_WD  = 10,
  parameter int CD_WD    = 8,
  parameter int FRAC_WD  = 4,
  parameter int ZONE_LEN = 64,
  parameter int SHIFT    = 0,
  parameter int OUT_WD   = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  dbf_channel_dynfocus_if.slave bus
);

  localparam int DEPTH = 1 << CD_WD;
  localparam int ZONES = 1 << ADDR_WD;
  localparam int LW    = CD_WD + FRAC_WD;
  localparam int PW    = INPUT_WD + APO_WD;
  localparam int RW    = (PW + 1 > OUT_WD) ? PW + 1 : OUT_WD;
  localparam int ZW    = (ZONE_LEN > 1) ? $clog2(ZONE_LEN) : 1;
  localparam int MW    = INPUT_WD + FRAC_WD + 2;

  localparam logic [CD_WD-1:0]   CMAX  = CD_WD'(DEPTH - 2);
  localparam logic [CD_WD:0]     NFULL = {1'b1, {CD_WD{1'b0}}};
  localparam logic [ZW-1:0]      ZCMAX = ZW'(ZONE_LEN - 1);
  localparam logic [ADDR_WD-1:0] ZLAST = '1;

  localparam logic signed [MW-1:0] RNDF = MW'(1 << (FRAC_WD - 1));
  localparam logic signed [RW-1:0] RNDO = RW'((1 << SHIFT) >> 1);
  localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_WD+1){1'b0}}, {(OUT_WD-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_WD+1){1'b1}}, {(OUT_WD-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACQ, HOLD} mode_e;

  // Floor shift plus half-LSB bias gives round-half-up; y stays between x0 and x1.
  function automatic logic signed [INPUT_WD-1:0] interp(
    input logic signed [INPUT_WD-1:0] x0,
    input logic signed [INPUT_WD-1:0] x1,
    input logic [FRAC_WD-1:0]         f
  );
    logic signed [INPUT_WD:0] d;
    logic signed [MW-1:0]     m;
    d = {x1[INPUT_WD-1], x1} - {x0[INPUT_WD-1], x0};
    m = d * $signed({1'b0, f});
    m = (m + RNDF) >>> FRAC_WD;
    return x0 + m[INPUT_WD-1:0];
  endfunction

  function automatic logic signed [OUT_WD-1:0] rnd_sat(input logic signed [PW-1:0] p);
    logic signed [RW-1:0] t;
    t = {{(RW-PW){p[PW-1]}}, p};
    t = (t + RNDO) >>> SHIFT;
    if (t > OMAX)      t = OMAX;
    else if (t < OMIN) t = OMIN;
    return t[OUT_WD-1:0];
  endfunction

  logic signed [INPUT_WD-1:0] smp_mem [DEPTH];
  logic [LW-1:0]              lut_mem [ZONES];

  mode_e mode;
  logic  acc;

  logic [CD_WD-1:0]   wp_q, wp_d;
  logic [CD_WD:0]     n_q, n_d, n_new;
  logic [ZW-1:0]      zcnt_q, zcnt_d;
  logic [ADDR_WD-1:0] zaddr_q, zaddr_d;

  logic [LW-1:0]      lut_word;
  logic [CD_WD-1:0]   c_raw, c_s1, a0_d, a1_d;
  logic [FRAC_WD-1:0] f_s1;
  logic               ok0_d, ok1_d;

  logic                       vld_p1_q, ok0_p1_q, ok1_p1_q;
  logic [CD_WD-1:0]           a0_p1_q, a1_p1_q;
  logic [FRAC_WD-1:0]         f_p1_q, f_p2_q;
  logic signed [APO_WD-1:0]   apo_p1_q, apo_p2_q, apo_p3_q;
  logic                       vld_p2_q, vld_p3_q, vld_p4_q;
  logic signed [INPUT_WD-1:0] x0_p2_q, x1_p2_q, y_p3_q;
  logic signed [INPUT_WD-1:0] cd_q;
  logic                       cd_vld_q;
  logic signed [PW-1:0]       p_p4_q;
  logic signed [OUT_WD-1:0]   dout_q;
  logic                       dout_vld_q;
  logic                       go_p2, go_p3, go_p4;

  always_comb begin
    mode = IDLE;
    if (bus.start) mode = bus.tx_en ? HOLD : ACQ;
  end

  assign acc   = (mode == ACQ);
  assign go_p2 = vld_p1_q & bus.start;
  assign go_p3 = vld_p2_q & bus.start;
  assign go_p4 = vld_p3_q & bus.start;

  // S1: delay word for the current zone, buffer addresses and warm-up masks
  assign lut_word = lut_mem[zaddr_q];
  assign c_raw    = lut_word[LW-1:FRAC_WD];
  assign f_s1     = lut_word[FRAC_WD-1:0];
  assign c_s1     = (c_raw > CMAX) ? CMAX : c_raw;
  assign n_new    = (n_q == NFULL) ? n_q : n_q + 1'b1;
  assign a0_d     = wp_q - c_s1;
  assign a1_d     = wp_q - c_s1 - 1'b1;
  assign ok0_d    = n_new > {1'b0, c_s1};
  assign ok1_d    = n_new > ({1'b0, c_s1} + 1'b1);

  always_comb begin
    wp_d    = wp_q;
    n_d     = n_q;
    zcnt_d  = zcnt_q;
    zaddr_d = zaddr_q;
    if (mode == IDLE) begin
      wp_d    = '0;
      n_d     = '0;
      zcnt_d  = '0;
      zaddr_d = '0;
    end else if (mode == ACQ) begin
      wp_d = wp_q + 1'b1;
      n_d  = n_new;
      if (zcnt_q == ZCMAX) begin
        zcnt_d = '0;
        if (zaddr_q != ZLAST) zaddr_d = zaddr_q + 1'b1;
      end else begin
        zcnt_d = zcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) smp_mem[wp_q] <= bus.ch_in;
  end

  always_ff @(posedge clk) begin
    if (bus.lut_we && !bus.start) lut_mem[bus.lut_addr] <= bus.lut_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      n_q        <= '0;
      zcnt_q     <= '0;
      zaddr_q    <= '0;
      vld_p1_q   <= 1'b0;
      ok0_p1_q   <= 1'b0;
      ok1_p1_q   <= 1'b0;
      a0_p1_q    <= '0;
      a1_p1_q    <= '0;
      f_p1_q     <= '0;
      apo_p1_q   <= '0;
      vld_p2_q   <= 1'b0;
      x0_p2_q    <= '0;
      x1_p2_q    <= '0;
      f_p2_q     <= '0;
      apo_p2_q   <= '0;
      vld_p3_q   <= 1'b0;
      y_p3_q     <= '0;
      apo_p3_q   <= '0;
      cd_q       <= '0;
      cd_vld_q   <= 1'b0;
      vld_p4_q   <= 1'b0;
      p_p4_q     <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      n_q     <= n_d;
      zcnt_q  <= zcnt_d;
      zaddr_q <= zaddr_d;

      vld_p1_q <= acc;
      ok0_p1_q <= ok0_d;
      ok1_p1_q <= ok1_d;
      a0_p1_q  <= a0_d;
      a1_p1_q  <= a1_d;
      f_p1_q   <= f_s1;
      apo_p1_q <= bus.apo_din;

      // S2: buffer reads; the S1 write has already landed, so c=0 sees the new sample
      vld_p2_q <= go_p2;
      x0_p2_q  <= ok0_p1_q ? smp_mem[a0_p1_q] : '0;
      x1_p2_q  <= ok1_p1_q ? smp_mem[a1_p1_q] : '0;
      f_p2_q   <= f_p1_q;
      apo_p2_q <= apo_p1_q;

      // S3: fine-delay interpolation and coarse-delay tap
      vld_p3_q <= go_p3;
      y_p3_q   <= interp(x0_p2_q, x1_p2_q, f_p2_q);
      apo_p3_q <= apo_p2_q;
      cd_vld_q <= go_p3;
      cd_q     <= go_p3 ? x0_p2_q : '0;

      // S4: apodisation
      vld_p4_q <= go_p4;
      p_p4_q   <= y_p3_q * apo_p3_q;

      // S5: round and saturate
      dout_vld_q <= vld_p4_q & bus.start;
      dout_q     <= (vld_p4_q & bus.start) ? rnd_sat(p_p4_q) : '0;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.dout_valid    = dout_vld_q;
  assign bus.cd_dout       = cd_q;
  assign bus.cd_dout_valid = cd_vld_q;

endmodule

// File: tb/tb_dbf_channel_dynfocus.sv
// Scoreboard bench for dbf_channel_dynfocus: directed vectors push expected
// value and arrival cycle; a negedge monitor pops and compares.
module tb_dbf_channel_dynfocus;
  localparam int INPUT_WD = 14;
  localparam int APO_WD   = 16;
  localparam int ADDR_WD  = 10;
  localparam int CD_WD    = 8;
  localparam int FRAC_WD  = 4;
  localparam int ZONE_LEN = 4;
  localparam int SHIFT    = 0;
  localparam int OUT_WD   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dbf_channel_dynfocus_if #(
    .INPUT_WD(INPUT_WD), .APO_WD(APO_WD), .ADDR_WD(ADDR_WD),
    .CD_WD(CD_WD), .FRAC_WD(FRAC_WD), .OUT_WD(OUT_WD)
  ) bus ();

  dbf_channel_dynfocus #(
    .INPUT_WD(INPUT_WD), .APO_WD(APO_WD), .ADDR_WD(ADDR_WD), .CD_WD(CD_WD),
    .FRAC_WD(FRAC_WD), .ZONE_LEN(ZONE_LEN), .SHIFT(SHIFT), .OUT_WD(OUT_WD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int val;
    int t;
  } exp_t;

  exp_t dq[$];
  exp_t cq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (bus.dout_valid) begin
        if (dq.size() == 0) begin
          check("dout_unexpected", int'(bus.dout), 999999);
        end else begin
          e = dq.pop_front();
          check("dout_value", int'(bus.dout), e.val);
          check("dout_cycle", cyc, e.t);
        end
      end else begin
        check("dout_idle_zero", int'(bus.dout), 0);
      end
      if (bus.cd_dout_valid) begin
        if (cq.size() == 0) begin
          check("cd_unexpected", int'(bus.cd_dout), 999999);
        end else begin
          e = cq.pop_front();
          check("cd_value", int'(bus.cd_dout), e.val);
          check("cd_cycle", cyc, e.t);
        end
      end else begin
        check("cd_idle_zero", int'(bus.cd_dout), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lut(input int addr, input int c, input int f);
    bus.start     = 1'b0;
    bus.tx_en     = 1'b0;
    bus.lut_we    = 1'b1;
    bus.lut_addr  = ADDR_WD'(addr);
    bus.lut_wdata = {CD_WD'(c), FRAC_WD'(f)};
    tick();
    bus.lut_we = 1'b0;
  endtask

  task automatic set_lut_all(input int c, input int f);
    for (int i = 0; i < (1 << ADDR_WD); i++) set_lut(i, c, f);
  endtask

  task automatic send(input int x, input int a, input int exp_d, input int exp_c);
    exp_t e;
    bus.start   = 1'b1;
    bus.tx_en   = 1'b0;
    bus.ch_in   = INPUT_WD'(x);
    bus.apo_din = APO_WD'(a);
    e.val = exp_d; e.t = cyc + 5; dq.push_back(e);
    e.val = exp_c; e.t = cyc + 3; cq.push_back(e);
    tick();
  endtask

  task automatic hold(input int n);
    bus.start = 1'b1;
    bus.tx_en = 1'b1;
    repeat (n) tick();
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    bus.tx_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    hold(7);
    idle(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout"}, int'(bus.dout), 0);
    check({tag, "_dout_valid"}, int'(bus.dout_valid), 0);
    check({tag, "_cd_dout"}, int'(bus.cd_dout), 0);
    check({tag, "_cd_valid"}, int'(bus.cd_dout_valid), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.tx_en     = 1'b0;
    bus.ch_in     = '0;
    bus.apo_din   = '0;
    bus.lut_we    = 1'b0;
    bus.lut_addr  = '0;
    bus.lut_wdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Pass-through
    set_lut_all(0, 0);
    for (int i = 1; i <= 8; i++) send(i, 1, i, i);
    drain();

    // Coarse delay 3 with warm-up zeros and a 2-cycle transmit gap
    set_lut_all(3, 0);
    for (int i = 1; i <= 5; i++) send(i, 1, (i > 3) ? i - 3 : 0, (i > 3) ? i - 3 : 0);
    hold(2);
    for (int i = 6; i <= 10; i++) send(i, 1, i - 3, i - 3);
    drain();

    // Fine delay, f = 8 (half sample)
    set_lut_all(0, 8);
    send(0, 1, 0, 0);
    send(100, 1, 50, 100);
    drain();
    send(1, 1, 1, 1);
    send(2, 1, 2, 2);
    drain();
    send(-1, 1, 0, -1);
    send(-2, 1, -1, -2);
    drain();

    // Zones: zone 0 pass-through, later zones coarse 2; LUT write during start ignored
    set_lut_all(2, 0);
    set_lut(0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      bus.lut_we    = (i == 2);
      bus.lut_addr  = ADDR_WD'(1);
      bus.lut_wdata = '0;
      send(i, 1, (i <= 4) ? i : i - 2, (i <= 4) ? i : i - 2);
    end
    bus.lut_we = 1'b0;
    drain();

    // Apodisation and saturation
    set_lut_all(0, 0);
    send(8191, 32767, 32767, 8191);
    send(-8192, 32767, -32768, -8192);
    send(100, -2, -200, 100);
    drain();

    // Mid-stream reset
    for (int i = 1; i <= 4; i++) send(i, 1, i, i);
    bus.start = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_outputs_zero("midreset");
    dq.delete();
    cq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    set_lut_all(0, 0);
    send(5, 1, 5, 5);
    send(6, 1, 6, 6);
    drain();

    check("dout_queue_empty", dq.size(), 0);
    check("cd_queue_empty", cq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
